// File: rtl/processor_stage2.sv
// Operand fetch: register read with writeback forwarding, ry+imm8 address, one-slot pipeline register.
// Latency: one cycle from an accepted instruction to the stage-3 slot; memory_addr/strobe are combinational.
// Backpressure: hold stalls stage 1 and inserts bubbles; call_performed squashes in-flight and FLUSH_CYCLES following.
module processor_stage2 #(
    parameter int ADDR_SIZE    = 18,
    parameter int WORD_SIZE    = 18,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 no_operation_in,
    input  logic [WORD_SIZE-1:0] code_word_in,
    input  logic [ADDR_SIZE-1:0] ip_in,
    input  logic                 hold,
    output logic                 stall_fetch,
    output logic [2:0]           reg_read_addr0,
    output logic [2:0]           reg_read_addr1,
    input  logic [WORD_SIZE-1:0] reg_read_data0,
    input  logic [WORD_SIZE-1:0] reg_read_data1,
    input  logic                 reg_write_enable,
    input  logic [2:0]           reg_write_addr,
    input  logic [WORD_SIZE-1:0] reg_write_data,
    input  logic                 call_performed,
    output logic [ADDR_SIZE-1:0] memory_addr,
    output logic                 memory_write_enable,
    output logic [WORD_SIZE-1:0] memory_write_data,
    output logic                 no_operation,
    output logic [WORD_SIZE-1:0] alu_data0,
    output logic [WORD_SIZE-1:0] alu_data1,
    output logic [WORD_SIZE-1:0] data1_plus_imm8,
    output logic [WORD_SIZE-1:0] code_word,
    output logic [ADDR_SIZE-1:0] ip,
    output logic [ADDR_SIZE-1:0] ip_plus_one
);

    // Opcode field occupies the top four bits of the code word.
    localparam logic [3:0] OP_REG_ADD_IMM8    = 4'h1;
    localparam logic [3:0] OP_WRITE_TO_MEMORY = 4'h3;

    // Squash counter states: zero is IDLE, anything else is FLUSH.
    localparam logic [1:0] SQUASH_IDLE = 2'd0;
    localparam logic [1:0] SQUASH_LOAD = 2'(FLUSH_CYCLES);

    logic [3:0]           top;
    logic [2:0]           rx;
    logic [2:0]           ry;
    logic [WORD_SIZE-1:0] op0;
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] imm;
    logic [WORD_SIZE-1:0] sum;
    logic [1:0]           squash_cnt;
    logic                 accept;

    assign top = code_word_in[17:14];
    assign rx  = code_word_in[13:11];
    assign ry  = code_word_in[10:8];

    assign reg_read_addr0 = rx;
    assign reg_read_addr1 = ry;
    assign stall_fetch    = hold;

    // Forward the stage-3 writeback so a result written this cycle is seen without a stall.
    always_comb begin
        op0 = reg_read_data0;
        op1 = reg_read_data1;
        if (reg_write_enable && (reg_write_addr == rx)) op0 = reg_write_data;
        if (reg_write_enable && (reg_write_addr == ry)) op1 = reg_write_data;
    end

    assign imm = {{(WORD_SIZE-8){code_word_in[7]}}, code_word_in[7:0]};
    assign sum = op1 + imm;

    assign accept = !no_operation_in && !hold && !call_performed && (squash_cnt == SQUASH_IDLE);

    // Address is driven every cycle so a load's data is ready when it reaches stage 3.
    assign memory_addr         = sum[ADDR_SIZE-1:0];
    assign memory_write_data   = op0;
    assign memory_write_enable = !reset && accept && (top == OP_WRITE_TO_MEMORY);

    // Count down squashed stage-1 instructions after a redirect; bubbles and held cycles do not count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            squash_cnt <= SQUASH_IDLE;
        end else if (call_performed) begin
            squash_cnt <= SQUASH_LOAD;
        end else if ((squash_cnt != SQUASH_IDLE) && !hold && !no_operation_in) begin
            squash_cnt <= squash_cnt - 2'd1;
        end
    end

    // Stage-3 slot: load operands on accept, otherwise present a bubble and keep the data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            no_operation    <= 1'b1;
            alu_data0       <= '0;
            alu_data1       <= '0;
            data1_plus_imm8 <= '0;
            code_word       <= '0;
            ip              <= '0;
            ip_plus_one     <= '0;
        end else if (accept) begin
            no_operation    <= 1'b0;
            alu_data0       <= op0;
            alu_data1       <= op1;
            data1_plus_imm8 <= sum;
            code_word       <= code_word_in;
            ip              <= ip_in;
            ip_plus_one     <= ip_in + ADDR_SIZE'(1);
        end else begin
            no_operation    <= 1'b1;
        end
    end

    // The add opcode needs no decode here; stage 3 consumes data1_plus_imm8 directly.
    logic unused_op;
    assign unused_op = (top == OP_REG_ADD_IMM8);

endmodule

// File: tb/tb_processor_stage2.sv
// Directed bench for processor_stage2 with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
// Register file read data is driven directly per vector.
module tb_processor_stage2;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h3;

    logic        clock = 1'b0;
    logic        reset;
    logic        no_operation_in;
    logic [17:0] code_word_in;
    logic [17:0] ip_in;
    logic        hold;
    logic        stall_fetch;
    logic [2:0]  reg_read_addr0;
    logic [2:0]  reg_read_addr1;
    logic [17:0] reg_read_data0;
    logic [17:0] reg_read_data1;
    logic        reg_write_enable;
    logic [2:0]  reg_write_addr;
    logic [17:0] reg_write_data;
    logic        call_performed;
    logic [17:0] memory_addr;
    logic        memory_write_enable;
    logic [17:0] memory_write_data;
    logic        no_operation;
    logic [17:0] alu_data0;
    logic [17:0] alu_data1;
    logic [17:0] data1_plus_imm8;
    logic [17:0] code_word;
    logic [17:0] ip;
    logic [17:0] ip_plus_one;

    int pass_cnt  = 0;
    int check_cnt = 0;

    processor_stage2 #(.ADDR_SIZE(18), .WORD_SIZE(18), .FLUSH_CYCLES(1)) dut (
        .clock               (clock),
        .reset               (reset),
        .no_operation_in     (no_operation_in),
        .code_word_in        (code_word_in),
        .ip_in               (ip_in),
        .hold                (hold),
        .stall_fetch         (stall_fetch),
        .reg_read_addr0      (reg_read_addr0),
        .reg_read_addr1      (reg_read_addr1),
        .reg_read_data0      (reg_read_data0),
        .reg_read_data1      (reg_read_data1),
        .reg_write_enable    (reg_write_enable),
        .reg_write_addr      (reg_write_addr),
        .reg_write_data      (reg_write_data),
        .call_performed      (call_performed),
        .memory_addr         (memory_addr),
        .memory_write_enable (memory_write_enable),
        .memory_write_data   (memory_write_data),
        .no_operation        (no_operation),
        .alu_data0           (alu_data0),
        .alu_data1           (alu_data1),
        .data1_plus_imm8     (data1_plus_imm8),
        .code_word           (code_word),
        .ip                  (ip),
        .ip_plus_one         (ip_plus_one)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] rx,
                                       input logic [2:0] ry, input logic [7:0] imm);
        return {op, rx, ry, imm};
    endfunction

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [17:0] cw, input logic [17:0] ipv,
                         input logic [17:0] d0, input logic [17:0] d1);
        no_operation_in = 1'b0;
        code_word_in    = cw;
        ip_in           = ipv;
        reg_read_data0  = d0;
        reg_read_data1  = d1;
    endtask

    initial begin
        reset = 1'b1; no_operation_in = 1'b1; code_word_in = '0; ip_in = '0; hold = 1'b0;
        reg_read_data0 = '0; reg_read_data1 = '0; reg_write_enable = 1'b0;
        reg_write_addr = '0; reg_write_data = '0; call_performed = 1'b0;
        #2;
        check("reset_noop", no_operation, 1);
        check("reset_ip1", ip_plus_one, 0);
        tick();
        reset = 1'b0;

        // Add with negative immediate: 5 + (-1) = 4.
        drive(mk(OP_ADD, 3'd1, 3'd2, 8'hFF), 18'h100, 18'd0, 18'd5);
        #1;
        check("add_raddr1", reg_read_addr1, 2);
        check("add_maddr", memory_addr, 4);
        check("add_we", memory_write_enable, 0);
        tick();
        check("add_noop", no_operation, 0);
        check("add_sum", data1_plus_imm8, 4);
        check("add_ip1", ip_plus_one, 18'h101);
        check("add_cw", code_word, mk(OP_ADD, 3'd1, 3'd2, 8'hFF));

        // Sum and ip+1 both wrap at 2^18.
        drive(mk(OP_ADD, 3'd1, 3'd2, 8'h01), 18'h3FFFF, 18'd0, 18'h3FFFF);
        tick();
        check("wrap_sum", data1_plus_imm8, 0);
        check("wrap_ip1", ip_plus_one, 0);
        check("wrap_ip", ip, 18'h3FFFF);

        // Forwarding on both ports from a same-cycle writeback of r3.
        drive(mk(OP_ADD, 3'd3, 3'd3, 8'h00), 18'h10, 18'h001, 18'h001);
        reg_write_enable = 1'b1; reg_write_addr = 3'd3; reg_write_data = 18'h123;
        tick();
        check("fwd_op0", alu_data0, 18'h123);
        check("fwd_op1", alu_data1, 18'h123);

        // Writeback to a different register must not forward.
        reg_write_addr = 3'd4;
        tick();
        check("nofwd_op0", alu_data0, 18'h001);
        reg_write_enable = 1'b0;

        // Store: r1=7 stored to r2 + 3.
        drive(mk(OP_STORE, 3'd1, 3'd2, 8'h03), 18'h20, 18'd7, 18'h100);
        #1;
        check("st_maddr", memory_addr, 18'h103);
        check("st_we", memory_write_enable, 1);
        check("st_wdata", memory_write_data, 7);
        tick();
        check("st_noop", no_operation, 0);

        // Same store with a redirect: suppressed now, then A squashed, B accepted.
        call_performed = 1'b1;
        #1;
        check("call_we", memory_write_enable, 0);
        tick();
        call_performed = 1'b0;
        check("call_noop", no_operation, 1);
        drive(mk(OP_ADD, 3'd0, 3'd0, 8'h0A), 18'h40, 18'd0, 18'd0);
        tick();
        check("flushA_noop", no_operation, 1);
        drive(mk(OP_ADD, 3'd0, 3'd0, 8'h0B), 18'h41, 18'd0, 18'd0);
        tick();
        check("flushB_noop", no_operation, 0);
        check("flushB_cw", code_word, mk(OP_ADD, 3'd0, 3'd0, 8'h0B));

        // Redirect again with an input bubble in between: bubble must not count.
        call_performed = 1'b1;
        tick();
        call_performed = 1'b0;
        no_operation_in = 1'b1;
        tick();
        check("bub_noop0", no_operation, 1);
        drive(mk(OP_ADD, 3'd0, 3'd0, 8'h0A), 18'h50, 18'd0, 18'd0);
        tick();
        check("bubA_noop", no_operation, 1);
        drive(mk(OP_ADD, 3'd0, 3'd0, 8'h0B), 18'h51, 18'd0, 18'd0);
        tick();
        check("bubB_noop", no_operation, 0);
        check("bubB_ip", ip, 18'h51);

        // Hold three cycles over a store: bubbles, stall, no write.
        drive(mk(OP_STORE, 3'd1, 3'd2, 8'h03), 18'h60, 18'd7, 18'h100);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_stall", stall_fetch, 1);
            check("hold_we", memory_write_enable, 0);
            tick();
            check("hold_noop", no_operation, 1);
        end
        hold = 1'b0;
        #1;
        check("rel_stall", stall_fetch, 0);
        check("rel_we", memory_write_enable, 1);
        tick();
        check("rel_noop", no_operation, 0);
        check("rel_op0", alu_data0, 7);
        check("rel_sum", data1_plus_imm8, 18'h103);
        no_operation_in = 1'b1;
        #1;
        check("once_we", memory_write_enable, 0);
        tick();
        check("once_noop", no_operation, 1);

        // Mid-cycle async reset with a store in flight and a flush pending.
        drive(mk(OP_ADD, 3'd1, 3'd2, 8'h05), 18'h70, 18'd9, 18'd1);
        tick();
        check("pre_rst_noop", no_operation, 0);
        call_performed = 1'b1;
        tick();
        call_performed = 1'b0;
        drive(mk(OP_STORE, 3'd1, 3'd2, 8'h03), 18'h80, 18'd7, 18'h100);
        #2;
        reset = 1'b1;
        #1;
        check("arst_noop", no_operation, 1);
        check("arst_op0", alu_data0, 0);
        check("arst_sum", data1_plus_imm8, 0);
        check("arst_cw", code_word, 0);
        check("arst_ip", ip, 0);
        check("arst_we", memory_write_enable, 0);
        check("arst_maddr", memory_addr, 18'h103);
        tick();
        reset = 1'b0;
        // Flush was cancelled, so the store is accepted immediately.
        #1;
        check("post_rst_we", memory_write_enable, 1);
        tick();
        check("post_rst_noop", no_operation, 0);
        check("post_rst_ip", ip, 18'h80);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/processor_stage2.md
# processor_stage2

Operand-fetch stage of the 18-bit pipeline, directly upstream of the execute/writeback stage. Takes the fetched code word, reads the register file with same-cycle forwarding from the writeback port, computes `ry + imm8`, and drives the synchronous data-memory address so load data arrives when the instruction reaches stage 3. Registers all operands into a one-cycle pipeline slot and squashes wrong-path instructions after a taken call or branch.

## Interface
- ADDR_SIZE, 18, instruction/data address width
- WORD_SIZE, 18, data word width
- FLUSH_CYCLES, 1, instructions from stage 1 squashed after `call_performed`, in addition to the one in flight here; legal range 0..3

- clock  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- no_operation_in  in  1  stage-1 slot is a bubble
- code_word_in  in  WORD_SIZE  fetched instruction
- ip_in  in  ADDR_SIZE  address of code_word_in
- hold  in  1  freeze request (debug/WAIT)
- stall_fetch  out  1  combinational copy of `hold`; stage 1 keeps its current outputs
- reg_read_addr0 / reg_read_addr1  out  3  `code_word_in[13:11]` (rx) / `code_word_in[10:8]` (ry)
- reg_read_data0 / reg_read_data1  in  WORD_SIZE  combinational register-file read data
- reg_write_enable, reg_write_addr[2:0], reg_write_data[WORD_SIZE]  in  stage-3 writeback, used for forwarding
- call_performed  in  1  stage 3 redirected fetch this cycle
- memory_addr  out  ADDR_SIZE  combinational data-memory address
- memory_write_enable  out  1  combinational store strobe; RAM writes on the clock edge
- memory_write_data  out  WORD_SIZE  store data
- no_operation, alu_data0, alu_data1, data1_plus_imm8, code_word, ip, ip_plus_one  out  registered stage-3 slot, widths as stage 3 expects

## Operation
- Forwarding: if `reg_write_enable` and `reg_write_addr` equals a read address, that operand takes `reg_write_data`, otherwise it takes the file data. Applies to both ports independently, all eight registers.
- `op1 = fwd(ry)`, `op0 = fwd(rx)`, `imm = sext(code_word_in[7:0])` to WORD_SIZE.
- `sum = op1 + imm`, WORD_SIZE bits, wraps mod 2^18.
- `memory_addr = sum[ADDR_SIZE-1:0]` every cycle; this serves loads.
- `memory_write_data = op0`.
- `memory_write_enable = accept & top==OP_WRITE_TO_MEMORY`.
- `accept = !no_operation_in & !hold & !call_performed & squash_cnt==0`.
- Slot update on each edge, unless reset:
  - if `accept`: `no_operation<=0`, `alu_data0<=op0`, `alu_data1<=op1`, `data1_plus_imm8<=sum`, `code_word<=code_word_in`, `ip<=ip_in`, `ip_plus_one<=ip_in+1` (wraps).
  - otherwise: `no_operation<=1`; the data registers keep their previous values.
- Squash counter `squash_cnt` (2 bits), states IDLE (0) and FLUSH (>0):
  - `call_performed` loads FLUSH_CYCLES; this has priority over everything else.
  - In FLUSH, decrement on each cycle with `!hold & !no_operation_in`. Held cycles and bubbles do not count.
- `hold` always produces a bubble. The input instruction is not consumed; stage 1 re-presents it.
- Reset values: `no_operation=1`; all other registered outputs 0; `squash_cnt=0`.
- Combinational outputs follow inputs during reset, except `memory_write_enable`, which is forced 0 while reset is high.

## Timing
- Latency: one cycle. The instruction accepted at edge N is in stage 3 during cycle N+1.
- Load data from the synchronous RAM appears on `memory_out` in cycle N+1, aligned with the instruction.
- A store is committed at edge N and is visible to a load issued in cycle N+1.
- `call_performed` in cycle N:
  - the instruction in stage 2 during cycle N becomes a bubble;
  - its store, if any, is suppressed in the same cycle;
  - the next FLUSH_CYCLES non-bubble instructions from stage 1 are also squashed.
- Back-to-back dependency (e.g. a load followed by a use of its result): resolved by forwarding, with no stall. The critical path is `memory_out` → stage-3 mux → forward → adder → `memory_addr`.
- Reset asserted mid-operation: the slot becomes a bubble and any in-progress FLUSH is cancelled.

## Test plan
- Reset pulse while a valid instruction is in flight → `no_operation=1` and all registered outputs 0 asynchronously, before the next edge; `memory_write_enable=0`.
- OP_REG_ADD_IMM8 with ry=r2=5 and imm8=0xFF → next cycle `data1_plus_imm8=4`, `ip_plus_one=ip+1`; with r2=0x3FFFF and imm8=0x01 → 0 (wrap).
- Stage 3 writes r3=0x123 in the same cycle stage 2 reads rx=r3 and ry=r3 (file holds 0x001) → `alu_data0=alu_data1=0x123`.
- OP_WRITE_TO_MEMORY with rx=r1=7, ry=r2=0x100, imm8=3 → `memory_addr=0x103`, `memory_write_enable=1`, `memory_write_data=7`; the same with `call_performed=1` → `memory_write_enable=0` and the next-cycle `no_operation=1`.
- `call_performed` with FLUSH_CYCLES=1, then a stream of valid instructions A, B, C → bubbles for the in-flight instruction and A; B reaches stage 3 two cycles after the call. Repeat with one input bubble inserted → the bubble does not count toward the flush.
- `hold=1` for 3 cycles over a store → 3 bubbles, `stall_fetch=1`, no write. After release the store is accepted exactly once and its operands are unchanged.
